// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-port signal bundle for mem_access_ctrl.
// master: the controller's view; slave: the requester/memory side.
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              req;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              verify_err;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read_write;
    logic              mem_enable;
    logic              mem_output_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output busy, done, rdata, verify_err,
        output mem_address, mem_read_write, mem_enable, mem_output_en, mem_wdata
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  busy, done, rdata, verify_err,
        input  mem_address, mem_read_write, mem_enable, mem_output_en, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Bus-master sequencer for the main memory port: turns a request pulse into a timed access.
// Optional write read-back check enabled by defining MEM_ACCESS_VERIFY_EN.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.master bus
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
`ifdef MEM_ACCESS_VERIFY_EN
        , S_VERIFY
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              en_q, en_d;
    logic              rw_q, rw_d;
    logic              oe_q, oe_d;
    logic              verr_q, verr_d;

    // State and registered outputs; reset leaves the port idle in read direction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            rw_q    <= 1'b1;
            oe_q    <= 1'b0;
            verr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            verr_q  <= verr_d;
        end
    end

    // Next state plus the output values the next state presents
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        en_d    = 1'b0;
        rw_d    = 1'b1;
        oe_d    = 1'b0;
        verr_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.req) begin
                    mar_d   = bus.req_addr;
                    mdr_d   = bus.req_wdata;
                    we_d    = bus.req_we;
                    state_d = S_ACCESS;
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                    rw_d    = ~bus.req_we;
                    oe_d    = ~bus.req_we;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
`ifdef MEM_ACCESS_VERIFY_EN
                    state_d = S_VERIFY;
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                    oe_d    = 1'b1;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(READ_LATENCY);
                    busy_d  = 1'b1;
                    oe_d    = 1'b1;
                end
            end
`ifdef MEM_ACCESS_VERIFY_EN
            S_VERIFY: begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(READ_LATENCY);
                busy_d  = 1'b1;
                oe_d    = 1'b1;
            end
`endif
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = bus.mem_rdata;
                    cnt_d   = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
`ifdef MEM_ACCESS_VERIFY_EN
                    verr_d  = we_q && (bus.mem_rdata != mdr_q);
`endif
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                    oe_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.rdata          = rdata_q;
    assign bus.mem_address    = mar_q;
    assign bus.mem_wdata      = mdr_q;
    assign bus.mem_read_write = rw_q;
    assign bus.mem_enable     = en_q;
    assign bus.mem_output_en  = oe_q;
`ifdef MEM_ACCESS_VERIFY_EN
    assign bus.verify_err     = verr_q;
`else
    assign bus.verify_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: two instances (read latency 1 and 4), each
// with a latency-accurate memory model and a queue of expected completions.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int unsigned WL1 = VERIFY ? 4 : 2;

    typedef struct {
        logic [15:0] data;
        logic        verr;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        corrupt;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          wr1 = 0;
    int          w0;
    exp_t        q1[$];
    exp_t        q4[$];
    logic [15:0] last1, last4;

    logic [15:0] m1 [0:65535];
    logic [15:0] m4 [0:65535];
    logic [15:0] raddr1 = '0, raddr4 = '0;
    logic [3:0]  age1 = '0, age4 = '0;

    mem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
    mem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) b4 ();

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(1)) d1 (
        .clk(clk), .reset(reset), .bus(b1.master));
    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(4)) d4 (
        .clk(clk), .reset(reset), .bus(b4.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: read data is garbage until READ_LATENCY edges after the sampling edge
    always @(posedge clk) begin
        if (b1.mem_enable && !b1.mem_read_write) m1[b1.mem_address] = b1.mem_wdata;
        if (b1.mem_enable && b1.mem_read_write) begin
            raddr1 <= b1.mem_address;
            age1   <= 4'd1;
        end else if (age1 != 4'hF) age1 <= age1 + 4'd1;
        if (b4.mem_enable && !b4.mem_read_write) m4[b4.mem_address] = b4.mem_wdata;
        if (b4.mem_enable && b4.mem_read_write) begin
            raddr4 <= b4.mem_address;
            age4   <= 4'd1;
        end else if (age4 != 4'hF) age4 <= age4 + 4'd1;
    end
    assign b1.mem_rdata = (age1 >= 4'd1) ? (m1[raddr1] ^ {15'b0, corrupt}) : 16'hDEAD;
    assign b4.mem_rdata = (age4 >= 4'd4) ? (m4[raddr4] ^ {15'b0, corrupt}) : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int sel, input logic r, input logic we,
                       input logic [15:0] a, input logic [15:0] d);
        if (sel == 1) begin
            b1.req = r; b1.req_we = we; b1.req_addr = a; b1.req_wdata = d;
        end else begin
            b4.req = r; b4.req_we = we; b4.req_addr = a; b4.req_wdata = d;
        end
    endtask

    // Drive an accepted request now and queue its expected completion
    task automatic start(input int sel, input logic we, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] rd);
        exp_t        e;
        int unsigned rl;
        rl = (sel == 1) ? 1 : 4;
        if (we) begin
            e.cyc  = cyc + (VERIFY ? 3 + rl : 2);
            e.data = VERIFY ? (d ^ {15'b0, corrupt}) : ((sel == 1) ? last1 : last4);
            e.verr = VERIFY & corrupt;
        end else begin
            e.cyc  = cyc + 2 + rl;
            e.data = rd;
            e.verr = 1'b0;
        end
        if (sel == 1) begin q1.push_back(e); last1 = e.data; end
        else          begin q4.push_back(e); last4 = e.data; end
        drv(sel, 1'b1, we, a, d);
    endtask

    task automatic drain(input int sel);
        int n;
        n = 0;
        while (((sel == 1) ? q1.size() : q4.size()) != 0 && n < 64) begin
            @(negedge clk); #1;
            n++;
        end
        chk($sformatf("drain%0d", sel), (sel == 1) ? q1.size() : q4.size(), 0);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_busy"}, b1.busy, 0);
        chk({tag, "_done"}, b1.done, 0);
        chk({tag, "_en"},   b1.mem_enable, 0);
        chk({tag, "_oe"},   b1.mem_output_en, 0);
        chk({tag, "_rw"},   b1.mem_read_write, 1);
        chk({tag, "_addr"}, b1.mem_address, 0);
        chk({tag, "_wd"},   b1.mem_wdata, 0);
        chk({tag, "_rd"},   b1.rdata, 0);
        chk({tag, "_verr"}, b1.verify_err, 0);
        chk({tag, "_rd4"},  b4.rdata, 0);
    endtask

    // Completion monitors: pop the oldest expectation on every done strobe
    always @(negedge clk) begin
        exp_t e;
        if (b1.done) begin
            if (q1.size() == 0) chk("d1_spurious_done", q1.size(), 1);
            else begin
                e = q1.pop_front();
                chk("d1_rdata", b1.rdata, e.data);
                chk("d1_verr", b1.verify_err, e.verr);
                chk("d1_done_cycle", cyc, e.cyc);
                chk("d1_done_busy", b1.busy, 0);
                chk("d1_done_en", b1.mem_enable, 0);
                chk("d1_done_rw", b1.mem_read_write, 1);
            end
        end else chk("d1_verr_nodone", b1.verify_err, 0);
        if (b4.done) begin
            if (q4.size() == 0) chk("d4_spurious_done", q4.size(), 1);
            else begin
                e = q4.pop_front();
                chk("d4_rdata", b4.rdata, e.data);
                chk("d4_verr", b4.verify_err, e.verr);
                chk("d4_done_cycle", cyc, e.cyc);
                chk("d4_done_busy", b4.busy, 0);
            end
        end else chk("d4_verr_nodone", b4.verify_err, 0);
    end

    always @(negedge clk) if (b1.mem_enable && !b1.mem_read_write) wr1 <= wr1 + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        corrupt = 1'b0;
        last1 = '0;
        last4 = '0;
        drv(1, 0, 0, 0, 0);
        drv(4, 0, 0, 0, 0);
        m1[16'h0010] = 16'h0BAD;
        m1[16'hFFFF] = 16'h1357;
        m4[16'h0002] = 16'h00A5;
        repeat (2) @(negedge clk);
        chk_rst("reset");
        reset = 1'b1;
        @(negedge clk);

        // Write 0xBEEF to 0x1234, then read it back
        w0 = wr1;
        @(negedge clk); start(1, 1, 16'h1234, 16'hBEEF, 16'h0);
        @(negedge clk); drv(1, 0, 0, 0, 0);
        chk("wr_en", b1.mem_enable, 1);
        chk("wr_rw", b1.mem_read_write, 0);
        chk("wr_oe", b1.mem_output_en, 0);
        chk("wr_addr", b1.mem_address, 16'h1234);
        chk("wr_wdata", b1.mem_wdata, 16'hBEEF);
        chk("wr_busy", b1.busy, 1);
        drain(1);
        chk("wr_single_enable", wr1 - w0, 1);
        @(negedge clk); start(1, 0, 16'h1234, 16'h0, 16'hBEEF);
        @(negedge clk); drv(1, 0, 0, 0, 0);
        chk("rd_en", b1.mem_enable, 1);
        chk("rd_rw", b1.mem_read_write, 1);
        chk("rd_oe", b1.mem_output_en, 1);
        @(negedge clk);
        chk("wait_en", b1.mem_enable, 0);
        chk("wait_oe", b1.mem_output_en, 1);
        chk("wait_busy", b1.busy, 1);
        drain(1);

        // Read latency 4: rdata must not move before the last WAIT edge
        @(negedge clk); start(4, 0, 16'h0002, 16'h0, 16'h00A5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) drv(4, 0, 0, 0, 0);
            chk("lat4_rdata_hold", b4.rdata, 0);
            chk("lat4_busy", b4.busy, 1);
        end
        drain(4);

        // Back-to-back with req held, then a read with a req pulse during WAIT
        w0 = wr1;
        @(negedge clk); start(1, 1, 16'h0001, 16'hAAAA, 16'h0);
        for (int k = 1; k < int'(WL1); k++) begin @(negedge clk); drv(1, 1, 0, 16'hFFF0, 16'h0); end
        @(negedge clk); start(1, 1, 16'h0002, 16'hBBBB, 16'h0);
        for (int k = 1; k < int'(WL1); k++) begin @(negedge clk); drv(1, 1, 0, 16'hFFF0, 16'h0); end
        @(negedge clk); start(1, 0, 16'h0001, 16'h0, 16'hAAAA);
        @(negedge clk); drv(1, 0, 0, 0, 0);
        @(negedge clk); drv(1, 1, 1, 16'h0003, 16'h7777);
        @(negedge clk); drv(1, 0, 0, 0, 0);
        drain(1);
        chk("b2b_write_count", wr1 - w0, 2);

        // Address extremes pass through unaltered
        @(negedge clk); start(1, 0, 16'hFFFF, 16'h0, 16'h1357);
        @(negedge clk); drv(1, 0, 0, 0, 0);
        chk("bnd_rd_addr", b1.mem_address, 16'hFFFF);
        drain(1);
        @(negedge clk);
        chk("idle_busy", b1.busy, 0);
        chk("idle_en", b1.mem_enable, 0);
        chk("idle_rw", b1.mem_read_write, 1);
        start(1, 1, 16'h0000, 16'h2468, 16'h0);
        @(negedge clk); drv(1, 0, 0, 0, 0);
        chk("bnd_wr_addr", b1.mem_address, 16'h0000);
        chk("bnd_wr_wdata", b1.mem_wdata, 16'h2468);
        chk("bnd_wr_busy", b1.busy, 1);
        drain(1);

        // Reset in the middle of a read: abort with no done and no capture
        @(negedge clk); drv(1, 1, 0, 16'h0010, 16'h0);
        @(negedge clk); drv(1, 0, 0, 0, 0);
        chk("abort_acc_en", b1.mem_enable, 1);
        #2 reset = 1'b0;
        #1 chk_rst("abort");
        last1 = '0;
        last4 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", b1.busy, 0);
        chk("post_rst_done", b1.done, 0);
        start(1, 0, 16'h0010, 16'h0, 16'h0BAD);
        @(negedge clk); drv(1, 0, 0, 0, 0);
        drain(1);

        // Write with a memory that flips bit 0 on read, then a clean write
        @(negedge clk); corrupt = 1'b1; start(4, 1, 16'h0005, 16'h5A5A, 16'h0);
        @(negedge clk); drv(4, 0, 0, 0, 0);
        drain(4);
        corrupt = 1'b0;
        @(negedge clk); start(4, 1, 16'h0006, 16'hC3C3, 16'h0);
        @(negedge clk); drv(4, 0, 0, 0, 0);
        drain(4);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
